// File: rtl/ddr_bist_pkg.sv
// Shared types and constants for the DDR3 built-in self-test engine.
package ddr_bist_pkg;

  localparam int unsigned ERR_W = 16;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_ALT55 = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CAL,
    ST_GAP_W,
    ST_WRITE,
    ST_GAP_R,
    ST_READ,
    ST_NEXT,
    ST_DONE
  } state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/ddr_test_pattern_gen.sv
// Registered beat generator; load presents beat 0 of a loop, advance steps to the next beat.
module ddr_test_pattern_gen
  import ddr_bist_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter logic [31:0] PATTERN_SEED = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  mode_e             mode,
  input  logic [7:0]        loop_seed,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] beat
);

  localparam int unsigned IDX_W = 16;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_nxt;
  logic [31:0]      seed0;
  logic [7:0]       loop_q;

  function automatic logic [DATA_W-1:0] pattern(input mode_e m, input logic [7:0] l,
                                                input logic [IDX_W-1:0] b, input logic [31:0] s);
    logic [63:0]       rep;
    logic [DATA_W-1:0] r;
    rep = {s, s};
    case (m)
      MODE_INCR:  r = DATA_W'(l) + DATA_W'(b);
      MODE_LFSR:  r = DATA_W'(rep);
      MODE_WALK1: r = DATA_W'(1) << (32'(b) % DATA_W);
      default:    r = b[0] ? {(DATA_W/8){8'hAA}} : {(DATA_W/8){8'h55}};
    endcase
    return r;
  endfunction

  assign seed0    = PATTERN_SEED ^ 32'(loop_seed);
  assign idx_nxt  = idx + IDX_W'(1);
  assign lfsr_nxt = lfsr_step(lfsr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      lfsr   <= '0;
      loop_q <= '0;
      beat   <= '0;
    end else if (load) begin
      idx    <= '0;
      lfsr   <= seed0;
      loop_q <= loop_seed;
      beat   <= pattern(mode, loop_seed, '0, seed0);
    end else if (advance) begin
      idx    <= idx_nxt;
      lfsr   <= lfsr_nxt;
      beat   <= pattern(mode, loop_q, idx_nxt, lfsr_nxt);
    end
  end

endmodule

// File: rtl/axi_ddr_bist.sv
// DDR3 write/readback self-test: per loop writes one pattern burst to a region,
// reads it back and counts mismatching, extra and missing beats.
module axi_ddr_bist
  import ddr_bist_pkg::*;
#(
  parameter int unsigned       DATA_W        = 8,
  parameter int unsigned       ADDR_W        = 32,
  parameter int unsigned       BURST_LEN     = 256,
  parameter int unsigned       BEAT_BYTES    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(32'h0100_0000),
  parameter logic [ADDR_W-1:0] REGION_STRIDE = ADDR_W'(32'h0001_0000),
  parameter int unsigned       NUM_REGIONS   = 4,
  parameter int unsigned       GAP_CYCLES    = 1000,
  parameter logic [31:0]       PATTERN_SEED  = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        num_loops,
  input  logic              stop,
  output logic              wr_begin,
  output logic              wr_data_valid,
  output logic [DATA_W-1:0] wr_data_in,
  output logic [ADDR_W-1:0] wr_addr_begin,
  output logic              rd_begin,
  output logic [ADDR_W-1:0] rd_addr_begin,
  output logic [ADDR_W-1:0] rd_addr_end,
  input  logic              rd_data_busy,
  input  logic [DATA_W-1:0] rd_data_out,
  input  logic              rd_valid_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [7:0]        loop_cnt
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned GAP_B = $clog2(GAP_CYCLES + 1);
  localparam int unsigned RX_W  = 16;
  localparam int unsigned SUM_W = ERR_W + 2;

  state_e            state;
  mode_e             mode_q;
  logic [7:0]        loops_q;
  logic              stop_q;
  logic [GAP_B-1:0]  gap_cnt;
  logic [CNT_W-1:0]  wcnt;
  logic [RX_W-1:0]   rx_cnt;
  logic              rd_busy_d1;
  logic              chk_v;
  logic              chk_extra;
  logic [DATA_W-1:0] chk_data;
  logic [DATA_W-1:0] chk_exp;
  logic [DATA_W-1:0] wgen_beat;
  logic [DATA_W-1:0] cgen_beat;

  logic              gap_done_c;
  logic              beat_c;
  logic              fall_c;
  logic              cal_lost_c;
  logic              wgen_load_c;
  logic              wgen_adv_c;
  logic              cgen_load_c;
  logic              cgen_adv_c;
  logic [ADDR_W-1:0] region_addr_c;
  logic [SUM_W-1:0]  rx_tot_c;
  logic [SUM_W-1:0]  miss_c;
  logic [SUM_W-1:0]  err_sum_c;
  logic [ERR_W-1:0]  err_next_c;

  assign gap_done_c    = (gap_cnt == GAP_B'(GAP_CYCLES - 1));
  assign beat_c        = (state == ST_READ) && rd_valid_out;
  assign fall_c        = (state == ST_READ) && rd_busy_d1 && !rd_data_busy;
  assign cal_lost_c    = !init_calib_complete &&
                         (state inside {ST_GAP_W, ST_WRITE, ST_GAP_R, ST_READ, ST_NEXT});
  assign wgen_load_c   = (state == ST_GAP_W) && gap_done_c;
  assign wgen_adv_c    = (state == ST_WRITE) && (wcnt < CNT_W'(BURST_LEN));
  assign cgen_load_c   = (state == ST_GAP_R) && gap_done_c;
  assign cgen_adv_c    = beat_c && (rx_cnt < RX_W'(BURST_LEN));
  assign region_addr_c = BASE_ADDR + ADDR_W'(32'(loop_cnt) % NUM_REGIONS) * REGION_STRIDE;

  // Error accumulation: pipelined compare, overrun beats and missing beats at busy fall
  always_comb begin
    rx_tot_c = SUM_W'(rx_cnt) + SUM_W'(beat_c);
    miss_c   = '0;
    if (fall_c && (rx_tot_c < SUM_W'(BURST_LEN)))
      miss_c = SUM_W'(BURST_LEN) - rx_tot_c;
    err_sum_c  = SUM_W'(err_cnt) + miss_c + SUM_W'(chk_v && (chk_data != chk_exp))
                 + SUM_W'(chk_extra);
    err_next_c = (err_sum_c > SUM_W'(16'hFFFF)) ? '1 : err_sum_c[ERR_W-1:0];
  end

  ddr_test_pattern_gen #(.DATA_W(DATA_W), .PATTERN_SEED(PATTERN_SEED)) u_wgen (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode_q),
    .loop_seed (loop_cnt),
    .load      (wgen_load_c),
    .advance   (wgen_adv_c),
    .beat      (wgen_beat)
  );

  ddr_test_pattern_gen #(.DATA_W(DATA_W), .PATTERN_SEED(PATTERN_SEED)) u_cgen (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode_q),
    .loop_seed (loop_cnt),
    .load      (cgen_load_c),
    .advance   (cgen_adv_c),
    .beat      (cgen_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      mode_q        <= MODE_INCR;
      loops_q       <= '0;
      stop_q        <= 1'b0;
      gap_cnt       <= '0;
      wcnt          <= '0;
      rx_cnt        <= '0;
      rd_busy_d1    <= 1'b0;
      chk_v         <= 1'b0;
      chk_extra     <= 1'b0;
      chk_data      <= '0;
      chk_exp       <= '0;
      wr_begin      <= 1'b0;
      wr_data_valid <= 1'b0;
      wr_data_in    <= '0;
      wr_addr_begin <= '0;
      rd_begin      <= 1'b0;
      rd_addr_begin <= '0;
      rd_addr_end   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      loop_cnt      <= '0;
    end else begin
      wr_begin      <= 1'b0;
      rd_begin      <= 1'b0;
      wr_data_valid <= 1'b0;
      rd_busy_d1    <= rd_data_busy;
      chk_v         <= cgen_adv_c;
      chk_extra     <= beat_c && (rx_cnt >= RX_W'(BURST_LEN));
      chk_data      <= rd_data_out;
      chk_exp       <= cgen_beat;
      err_cnt       <= err_next_c;
      if (beat_c && (rx_cnt != '1))
        rx_cnt <= rx_cnt + RX_W'(1);
      // stop is honoured at the end of the loop even if it is released early
      if (stop && busy)
        stop_q <= 1'b1;

      if (cal_lost_c) begin
        state   <= ST_DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        pass    <= 1'b0;
        err_cnt <= (err_next_c == '0) ? ERR_W'(1) : err_next_c;
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state    <= ST_WAIT_CAL;
              mode_q   <= mode_e'(mode);
              loops_q  <= num_loops;
              stop_q   <= 1'b0;
              err_cnt  <= '0;
              loop_cnt <= '0;
              done     <= 1'b0;
              pass     <= 1'b0;
              busy     <= 1'b1;
            end
          end
          ST_WAIT_CAL: begin
            if (init_calib_complete) begin
              state   <= ST_GAP_W;
              gap_cnt <= '0;
            end
          end
          ST_GAP_W: begin
            if (gap_done_c) begin
              state         <= ST_WRITE;
              wr_begin      <= 1'b1;
              wr_addr_begin <= region_addr_c;
              wcnt          <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_B'(1);
            end
          end
          ST_WRITE: begin
            if (wcnt < CNT_W'(BURST_LEN)) begin
              wr_data_valid <= 1'b1;
              wr_data_in    <= wgen_beat;
              wcnt          <= wcnt + CNT_W'(1);
            end else begin
              state   <= ST_GAP_R;
              gap_cnt <= '0;
            end
          end
          ST_GAP_R: begin
            if (gap_done_c) begin
              state         <= ST_READ;
              rd_begin      <= 1'b1;
              rd_addr_begin <= region_addr_c;
              rd_addr_end   <= region_addr_c + ADDR_W'((BURST_LEN - 1) * BEAT_BYTES);
              rx_cnt        <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_B'(1);
            end
          end
          ST_READ: begin
            if (fall_c)
              state <= ST_NEXT;
          end
          ST_NEXT: begin
            loop_cnt <= loop_cnt + 8'd1;
            if (((loops_q != 8'd0) && ((loop_cnt + 8'd1) == loops_q)) || stop || stop_q) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next_c == '0);
            end else begin
              state   <= ST_GAP_W;
              gap_cnt <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_ddr_bist.sv
// Scoreboard bench for axi_ddr_bist with a behavioural DDR front-end and memory.
module tb_axi_ddr_bist;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BURST_LEN   = 256;
  localparam int unsigned BEAT_BYTES  = 16;
  localparam int unsigned NUM_REGIONS = 4;
  localparam int unsigned GAP_CYCLES  = 8;
  localparam logic [31:0] BASE        = 32'h0100_0000;
  localparam logic [31:0] STRIDE      = 32'h0001_0000;
  localparam logic [31:0] SEED        = 32'hACE1_0001;
  localparam logic [31:0] TAPS        = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              init_calib_complete = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [7:0]        num_loops = 8'd0;
  logic              stop = 1'b0;
  logic              wr_begin;
  logic              wr_data_valid;
  logic [DATA_W-1:0] wr_data_in;
  logic [ADDR_W-1:0] wr_addr_begin;
  logic              rd_begin;
  logic [ADDR_W-1:0] rd_addr_begin;
  logic [ADDR_W-1:0] rd_addr_end;
  logic              rd_data_busy = 1'b0;
  logic [DATA_W-1:0] rd_data_out = '0;
  logic              rd_valid_out = 1'b0;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       err_cnt;
  logic [7:0]        loop_cnt;

  axi_ddr_bist #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .BEAT_BYTES(BEAT_BYTES),
    .BASE_ADDR(BASE), .REGION_STRIDE(STRIDE), .NUM_REGIONS(NUM_REGIONS),
    .GAP_CYCLES(GAP_CYCLES), .PATTERN_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete), .start(start),
    .mode(mode), .num_loops(num_loops), .stop(stop),
    .wr_begin(wr_begin), .wr_data_valid(wr_data_valid), .wr_data_in(wr_data_in),
    .wr_addr_begin(wr_addr_begin), .rd_begin(rd_begin), .rd_addr_begin(rd_addr_begin),
    .rd_addr_end(rd_addr_end), .rd_data_busy(rd_data_busy), .rd_data_out(rd_data_out),
    .rd_valid_out(rd_valid_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        pass;
    logic [15:0] err;
    logic [7:0]  loops;
  } done_t;

  logic [7:0]  exp_wdata[$];
  logic [31:0] exp_waddr[$];
  logic [63:0] exp_raddr[$];
  done_t       exp_done[$];

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] wbase = '0;
  int          wbeat = 0;
  logic [31:0] rbase = '0;
  logic        done_d = 1'b0;
  int          n_beats = 256;
  int          flip_a = -1;
  int          flip_b = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected write stream and addresses of one loop
  task automatic push_loop(input int m, input int l);
    logic [31:0] s;
    logic [31:0] a;
    logic [7:0]  d;
    s = SEED ^ 32'(l);
    a = BASE + 32'(l % NUM_REGIONS) * STRIDE;
    exp_waddr.push_back(a);
    exp_raddr.push_back({a, a + 32'((BURST_LEN - 1) * BEAT_BYTES)});
    for (int b = 0; b < BURST_LEN; b++) begin
      case (m)
        0:       d = 8'(l + b);
        1:       d = s[7:0];
        2:       d = 8'(1 << (b % 8));
        default: d = (b % 2 == 0) ? 8'h55 : 8'hAA;
      endcase
      exp_wdata.push_back(d);
      s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    end
  endtask

  task automatic pulse_start(input int m, input int loops);
    @(negedge clk);
    mode      = 2'(m);
    num_loops = 8'(loops);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
    @(negedge clk);
    check({name, "_wdata_left"}, 64'(exp_wdata.size()), 64'd0);
    check({name, "_done_left"}, 64'(exp_done.size()), 64'd0);
  endtask

  task automatic run(input string name, input int m, input int loops,
                     input logic ep, input int ee, input int el);
    for (int l = 0; l < loops; l++) push_loop(m, l);
    exp_done.push_back({ep, 16'(ee), 8'(el)});
    pulse_start(m, loops);
    wait_done(name);
  endtask

  // Monitor: memory capture plus scoreboard comparisons on every DUT strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_begin) begin
        wbase = wr_addr_begin;
        wbeat = 0;
        check("wr_addr_q_avail", 64'(exp_waddr.size() > 0), 64'd1);
        if (exp_waddr.size() > 0) check("wr_addr_begin", 64'(wr_addr_begin), 64'(exp_waddr.pop_front()));
      end
      if (wr_data_valid) begin
        mem[wbase + 32'(wbeat) * BEAT_BYTES] = wr_data_in;
        wbeat++;
        if (exp_wdata.size() == 0) check("wr_data_q_avail", 64'(exp_wdata.size()), 64'd1);
        else check("wr_data_in", 64'(wr_data_in), 64'(exp_wdata.pop_front()));
      end
      if (rd_begin) begin
        logic [63:0] r;
        check("rd_addr_q_avail", 64'(exp_raddr.size() > 0), 64'd1);
        if (exp_raddr.size() > 0) begin
          r = exp_raddr.pop_front();
          check("rd_addr_begin", 64'(rd_addr_begin), 64'(r[63:32]));
          check("rd_addr_end", 64'(rd_addr_end), 64'(r[31:0]));
        end
      end
      if (done && !done_d) begin
        done_t e;
        check("done_q_avail", 64'(exp_done.size() > 0), 64'd1);
        if (exp_done.size() > 0) begin
          e = exp_done.pop_front();
          check("pass", 64'(pass), 64'(e.pass));
          check("err_cnt", 64'(err_cnt), 64'(e.err));
          check("loop_cnt", 64'(loop_cnt), 64'(e.loops));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
    done_d = done;
  end

  // Read-side front-end: returns stored beats, optionally flipped, truncated or overrun
  initial begin
    forever begin
      @(negedge clk);
      if (rd_begin && !rst) begin
        rbase        = rd_addr_begin;
        rd_data_busy = 1'b1;
        @(negedge clk);
        for (int b = 0; b < n_beats; b++) begin
          @(negedge clk);
          if (rst) break;
          rd_valid_out = 1'b1;
          rd_data_out  = mem.exists(rbase + 32'(b) * BEAT_BYTES) ?
                         mem[rbase + 32'(b) * BEAT_BYTES] : 8'h00;
          if (b == flip_a || b == flip_b) rd_data_out = rd_data_out ^ 8'h01;
        end
        if (!rst) @(negedge clk);
        rd_valid_out = 1'b0;
        rd_data_busy = 1'b0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_wr_data_valid", 64'(wr_data_valid), 64'd0);
    check("rst_wr_addr_begin", 64'(wr_addr_begin), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    init_calib_complete = 1'b1;

    // INCR single loop against ideal memory
    run("incr", 0, 1, 1'b1, 0, 1);

    // LFSR over six loops walking all regions
    run("lfsr", 1, 6, 1'b1, 0, 6);

    // WALK1 with bit 0 flipped on beats 3 and 100
    flip_a = 3;
    flip_b = 100;
    run("walk1_flip", 2, 1, 1'b0, 2, 1);
    flip_a = -1;
    flip_b = -1;

    // ALT55 with a short read burst, then an overrun burst
    n_beats = 250;
    run("alt55_short", 3, 1, 1'b0, 6, 1);
    n_beats = 258;
    run("alt55_long", 3, 1, 1'b0, 2, 1);
    n_beats = 256;

    // Free-running loops stopped during the write of loop 2
    for (int l = 0; l < 3; l++) push_loop(0, l);
    exp_done.push_back({1'b1, 16'd0, 8'd3});
    pulse_start(0, 0);
    n = 0;
    while (!(wr_begin && wr_addr_begin == BASE + 2 * STRIDE) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("stop_loop2_wr_begin", 64'(wr_begin), 64'd1);
    repeat (40) @(negedge clk);
    stop = 1'b1;
    wait_done("stop");
    stop = 1'b0;

    // Reset in the middle of a read, then a clean rerun
    push_loop(0, 0);
    pulse_start(0, 1);
    n = 0;
    while (!rd_begin && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_rd_begin_seen", 64'(rd_begin), 64'd1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    check("rstmid_pass", 64'(pass), 64'd0);
    check("rstmid_err_cnt", 64'(err_cnt), 64'd0);
    check("rstmid_loop_cnt", 64'(loop_cnt), 64'd0);
    check("rstmid_strobes", 64'({wr_begin, wr_data_valid, rd_begin}), 64'd0);
    check("rstmid_wr_data_in", 64'(wr_data_in), 64'd0);
    check("rstmid_wr_addr_begin", 64'(wr_addr_begin), 64'd0);
    check("rstmid_rd_addr_begin", 64'(rd_addr_begin), 64'd0);
    check("rstmid_rd_addr_end", 64'(rd_addr_end), 64'd0);
    check("rstmid_wdata_left", 64'(exp_wdata.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_rd_idle", 64'({rd_data_busy, rd_valid_out}), 64'd0);
    run("after_rst", 0, 1, 1'b1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
